// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and fetch fault encoding
package riscv_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Misalignment is reported ahead of range so a bad low address never reads as a range error.
  function automatic logic [1:0] fetch_fault(input logic misaligned, input logic out_of_range);
    if (misaligned) begin
      return FAULT_MISALIGN;
    end else if (out_of_range) begin
      return FAULT_RANGE;
    end
    return FAULT_OK;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - word array with one synchronous write and one synchronous read port
module imem_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - loadable instruction memory with fetch handshake and fault reporting
module imem_loadable
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int BOOT_LOAD = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_last,
  input  logic                       reload,
  output logic                       loaded,
  output logic [$clog2(DEPTH+1)-1:0] load_count,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_inst,
  output logic [1:0]                 rsp_fault
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic              ld_fire;
  logic              fetch_fire;
  logic              misaligned;
  logic              out_of_range;
  logic              last_beat;
  logic              rsp_mem;
  logic [DATA_W-1:0] ram_q;

  assign misaligned = |fetch_addr[1:0];

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  generate
    if (ADDR_W > IW + 2) begin : g_range
      assign out_of_range = |fetch_addr[ADDR_W-1:IW+2];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign ld_ready    = (state == ST_LOAD);
  assign loaded      = (state == ST_RUN);
  assign fetch_ready = (state == ST_RUN) && !reload && (!rsp_valid || rsp_ready);
  assign ld_fire     = ld_valid && ld_ready;
  assign fetch_fire  = fetch_valid && fetch_ready;
  assign last_beat   = ld_last || (load_count == LAST_IDX);

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ld_fire),
    .wr_addr (load_count[IW-1:0]),
    .wr_data (ld_data),
    .rd_en   (fetch_fire && !misaligned && !out_of_range),
    .rd_addr (fetch_addr[IW+1:2]),
    .rd_data (ram_q)
  );

  // ram_q only moves on an accepted fetch, so a stalled response stays stable.
  assign rsp_inst = rsp_mem ? ram_q :
                    (rsp_fault == FAULT_OK) ? '0 : DATA_W'(RV_NOP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;
      load_count <= '0;
      rsp_valid  <= 1'b0;
      rsp_fault  <= FAULT_OK;
      rsp_mem    <= 1'b0;
    end else begin
      if (state == ST_LOAD) begin
        if (ld_fire) begin
          load_count <= load_count + CW'(1);
          if (last_beat) begin
            state <= ST_RUN;
          end
        end
      end else if (reload && !rsp_valid) begin
        state      <= ST_LOAD;
        load_count <= '0;
      end

      if (fetch_fire) begin
        rsp_valid <= 1'b1;
        rsp_fault <= fetch_fault(misaligned, out_of_range);
        rsp_mem   <= !misaligned && !out_of_range;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - self-checking bench for imem_loadable
module tb_imem_loadable;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              reload = 1'b0;
  logic              loaded;
  logic [CW-1:0]     load_count;
  logic              fetch_valid = 1'b0;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_inst;
  logic [1:0]        rsp_fault;

  imem_loadable #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BOOT_LOAD (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .reload      (reload),
    .loaded      (loaded),
    .load_count  (load_count),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_inst    (rsp_inst),
    .rsp_fault   (rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] inst;
    logic [1:0]  fault;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference: contents of every word the bench has written, and how far the current load got.
  logic [31:0] model_mem [DEPTH];
  bit          written   [DEPTH];
  int          model_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_fetch(input logic [15:0] a, output logic [31:0] inst,
                                    output logic [1:0] f, output bit known);
    int idx;
    idx   = int'(a) / 4;
    known = 1'b1;
    if (int'(a) % 4 != 0) begin
      inst = 32'h0000_0013;
      f    = 2'b01;
    end else if (idx >= DEPTH) begin
      inst = 32'h0000_0013;
      f    = 2'b10;
    end else begin
      inst  = model_mem[idx];
      f     = 2'b00;
      known = written[idx];
    end
  endfunction

  task automatic load_beat(input logic [31:0] d, input bit last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    check("ld_ready", ld_ready, 1);
    tick;
    model_mem[model_count] = d;
    written[model_count]   = 1'b1;
    model_count++;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch_check(input logic [15:0] a, input string name);
    logic [31:0] ei;
    logic [1:0]  ef;
    bit          kn;
    ref_fetch(a, ei, ef, kn);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    rsp_ready   = 1'b1;
    #1;
    check({name, "_fetch_ready"}, fetch_ready, 1);
    tick;
    fetch_valid = 1'b0;
    check({name, "_rsp_valid"}, rsp_valid, 1);
    check({name, "_rsp_fault"}, rsp_fault, ef);
    if (kn) check({name, "_rsp_inst"}, rsp_inst, ei);
    tick;
  endtask

  initial begin
    vec_t        vecs [7];
    logic [31:0] ei;
    logic [1:0]  ef;
    bit          kn;
    bit          have_rsp;
    bit          fv, rr, exp_fr;
    logic [15:0] a;
    logic [31:0] held;

    vecs[0] = '{16'h0000, 32'h0000_0000, 2'b00};
    vecs[1] = '{16'h0004, 32'h0012_8293, 2'b00};
    vecs[2] = '{16'h0008, 32'h0012_8293, 2'b00};
    vecs[3] = '{16'h000C, 32'h4072_81B3, 2'b00};
    vecs[4] = '{16'h0006, 32'h0000_0013, 2'b01};
    vecs[5] = '{16'h0800, 32'h0000_0013, 2'b10};
    vecs[6] = '{16'h0802, 32'h0000_0013, 2'b01};

    tick;
    tick;
    rst_n = 1'b1;
    #1;
    check("rst_loaded", loaded, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_fetch_ready", fetch_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_inst", rsp_inst, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_load_count", load_count, 0);

    // Boot load of four words, ld_last on the fourth.
    load_beat(32'h0000_0000, 1'b0);
    load_beat(32'h0012_8293, 1'b0);
    load_beat(32'h0012_8293, 1'b0);
    check("boot_still_load", loaded, 0);
    load_beat(32'h4072_81B3, 1'b1);
    check("boot_loaded", loaded, 1);
    check("boot_count", load_count, 4);
    check("boot_ld_ready", ld_ready, 0);

    // Table vectors back to back with rsp_ready held high.
    for (int i = 0; i < 7; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = vecs[i].addr;
      rsp_ready   = 1'b1;
      #1;
      check($sformatf("vec%0d_fetch_ready", i), fetch_ready, 1);
      tick;
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("vec%0d_rsp_inst", i), rsp_inst, vecs[i].inst);
      check($sformatf("vec%0d_rsp_fault", i), rsp_fault, vecs[i].fault);
    end
    fetch_valid = 1'b0;
    tick;
    check("vec_drain", rsp_valid, 0);

    // Stall: response must hold while rsp_ready is low, then retire with a new fetch.
    fetch_valid = 1'b1;
    fetch_addr  = 16'h000C;
    rsp_ready   = 1'b0;
    tick;
    held = rsp_inst;
    check("stall_first", held, 32'h4072_81B3);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 16'h0008;
      #1;
      check($sformatf("stall%0d_fetch_ready", i), fetch_ready, 0);
      tick;
      check($sformatf("stall%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("stall%0d_rsp_inst", i), rsp_inst, 32'h4072_81B3);
      check($sformatf("stall%0d_rsp_fault", i), rsp_fault, 0);
    end
    rsp_ready  = 1'b1;
    fetch_addr = 16'h0004;
    #1;
    check("b2b_fetch_ready", fetch_ready, 1);
    tick;
    fetch_valid = 1'b0;
    check("b2b_rsp_valid", rsp_valid, 1);
    check("b2b_rsp_inst", rsp_inst, 32'h0012_8293);
    tick;

    // Reload requested while a response is stalled.
    fetch_valid = 1'b1;
    fetch_addr  = 16'h0000;
    rsp_ready   = 1'b0;
    tick;
    fetch_valid = 1'b0;
    reload      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("rl_hold%0d_fetch_ready", i), fetch_ready, 0);
      tick;
      check($sformatf("rl_hold%0d_loaded", i), loaded, 1);
      check($sformatf("rl_hold%0d_rsp_valid", i), rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    tick;
    check("rl_drain_valid", rsp_valid, 0);
    check("rl_drain_loaded", loaded, 1);
    tick;
    reload = 1'b0;
    check("rl_loaded", loaded, 0);
    check("rl_count", load_count, 0);
    model_count = 0;
    load_beat(32'hAAAA_AAAA, 1'b1);
    check("rl1_loaded", loaded, 1);
    check("rl1_count", load_count, 1);
    fetch_check(16'h0000, "rl1_w0");
    fetch_check(16'h0004, "rl1_w1");
    check("rl1_w1_kept", model_mem[1], 32'h0012_8293);

    // Full-depth load with no ld_last.
    reload = 1'b1;
    tick;
    reload = 1'b0;
    check("full_enter_load", loaded, 0);
    model_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_pre_last_loaded", loaded, 0);
      load_beat($urandom, 1'b0);
    end
    check("full_loaded", loaded, 1);
    check("full_count", load_count, DEPTH);
    fetch_check(16'h07FC, "full_last_word");
    fetch_check(16'h0000, "full_first_word");

    // Random traffic with random backpressure against the reference model.
    have_rsp = 1'b0;
    ei = '0;
    ef = '0;
    for (int n = 0; n < 300; n++) begin
      fv = 1'($urandom);
      rr = 1'($urandom);
      a  = ($urandom % 2 == 0) ? 16'($urandom_range(0, 2047)) : 16'($urandom);
      fetch_valid = fv;
      fetch_addr  = a;
      rsp_ready   = rr;
      exp_fr      = !have_rsp || rr;
      #1;
      check("rnd_fetch_ready", fetch_ready, exp_fr);
      tick;
      if (have_rsp && rr) have_rsp = 1'b0;
      if (fv && exp_fr) begin
        have_rsp = 1'b1;
        ref_fetch(a, ei, ef, kn);
      end
      check("rnd_rsp_valid", rsp_valid, have_rsp);
      if (have_rsp) begin
        check("rnd_rsp_fault", rsp_fault, ef);
        check("rnd_rsp_inst", rsp_inst, ei);
      end
    end
    fetch_valid = 1'b0;
    rsp_ready   = 1'b1;
    tick;

    // Reset with a response pending.
    fetch_valid = 1'b1;
    fetch_addr  = 16'h0010;
    rsp_ready   = 1'b0;
    tick;
    fetch_valid = 1'b0;
    check("rstrsp_pending", rsp_valid, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("rstrsp_valid", rsp_valid, 0);
    check("rstrsp_loaded", loaded, 0);
    check("rstrsp_count", load_count, 0);
    model_count = 0;

    // Reset after two of four beats.
    load_beat(32'h1111_1111, 1'b0);
    load_beat(32'h2222_2222, 1'b0);
    check("midload_count", load_count, 2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    model_count = 0;
    check("midload_rst_loaded", loaded, 0);
    check("midload_rst_count", load_count, 0);
    check("midload_rst_ld_ready", ld_ready, 1);
    load_beat(32'h3333_3333, 1'b1);
    check("midload_reload_loaded", loaded, 1);
    fetch_check(16'h0000, "midload_w0");
    fetch_check(16'h0004, "midload_w1");
    fetch_check(16'h0008, "midload_w2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the single-cycle RV32I core. It replaces the fixed combinational ROM with synchronous storage that a boot loader fills through a streaming load port. Instructions are then served through a fetch request/response handshake with one-cycle latency. It sits between the PC/fetch logic and the external loader, and reports misaligned and out-of-range fetches as faults instead of returning undefined data.

## Interface
Parameters:
- ADDR_W, 16, byte-address width of fetch_addr
- DATA_W, 32, instruction word width
- DEPTH, 512, number of words; power of two, DEPTH*4 <= 2^ADDR_W
- BOOT_LOAD, 1, 1: enter LOAD after reset; 0: enter RUN directly

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, synchronous, active-low
- ld_valid  in  1  load beat present
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready
- ld_data  in  DATA_W  word to store
- ld_last  in  1  final beat of the load stream
- reload  in  1  request to return from RUN to LOAD
- loaded  out  1  high in RUN
- load_count  out  $clog2(DEPTH+1)  words written in the current/last load
- fetch_valid  in  1  fetch request
- fetch_ready  out  1  request accepted when fetch_valid && fetch_ready
- fetch_addr  in  ADDR_W  byte address
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_inst  out  DATA_W  instruction word
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range

## Operation
- States: LOAD, RUN. Reset → LOAD if BOOT_LOAD=1, else RUN.
- Reset values: rsp_valid=0, rsp_inst=0, rsp_fault=00, load_count=0, loaded=(BOOT_LOAD==0). Reset does not clear the array.
- LOAD: ld_ready=1 and fetch_ready=0. Each accepted beat writes ld_data to word[load_count] and increments load_count.
  - Go to RUN after accepting a beat with ld_last=1, or a beat at load_count==DEPTH-1, whichever comes first.
- RUN: ld_ready=0. fetch_ready = !reload && (!rsp_valid || rsp_ready).
- On an accepted fetch, word index = fetch_addr[ADDR_W-1:2].
  - fetch_addr[1:0] != 0: rsp_fault=01, rsp_inst=32'h0000_0013 (NOP).
  - Otherwise, index >= DEPTH: rsp_fault=10, rsp_inst=NOP.
  - Otherwise: rsp_fault=00, rsp_inst=word[index].
  - Misaligned takes priority over out of range.
- Response hold: rsp_valid, rsp_inst and rsp_fault stay stable while rsp_valid && !rsp_ready.
- Reload: reload=1 in RUN with rsp_valid=0 moves to LOAD next cycle and sets load_count=0. While rsp_valid=1, reload is held off until the response drains. reload is ignored in LOAD.
- Partial loads: words beyond the new load_count keep their old contents.

## Timing
- Fetch latency is 1 cycle: a fetch accepted at edge N gives rsp_valid=1 after edge N. With rsp_ready held high, one fetch per cycle is sustained.
- Load: one beat per cycle. A write at edge N is visible to a fetch accepted at edge N+1 or later.
- The LOAD→RUN transition takes effect on the edge that accepts the last beat. fetch_ready can be 1 in the next cycle.
- Reset mid-load returns to LOAD with load_count=0. Reset mid-response drops rsp_valid.
- Simultaneous rsp_ready and new fetch: the old response retires and the new one loads on the same edge.

## Structure
- riscv_pkg holds shared constants: RV_NOP=32'h0000_0013 and the fault codes FAULT_OK, FAULT_MISALIGN, FAULT_RANGE.
- The sub-module imem_ram (DEPTH×DATA_W, one synchronous write port, one synchronous read port, no reset) holds the array.
- The FSM, load counter, fault decode and response register live in imem_loadable.

## Test plan
- Reset with BOOT_LOAD=1, stream 4 words {00000000, 00128293, 00128293, 407281B3} with ld_last on beat 4 → loaded=1 next cycle, load_count=4. Fetches at 0x0,0x4,0x8,0xC return these words with fault 00 at 1-cycle latency.
- In RUN, fetch 0x6 → rsp_inst=00000013, fault=01. Fetch 0x0800 (index 512, DEPTH=512) → NOP, fault=10. Fetch 0x0802 → fault=01.
- Hold rsp_ready=0 for 3 cycles after a fetch → fetch_ready=0 and response stable. Raise rsp_ready with fetch_valid at 0x4 → back-to-back response next cycle.
- Load 512 words without ld_last → transition to RUN after beat 512. Fetch 0x7FC returns beat 512.
- Pulse reload while rsp_valid=1 and rsp_ready=0 → no state change until the response is taken, then LOAD with load_count=0. Reload 1 word AAAA_AAAA → word 0 updated, word 1 keeps 00128293.
- Assert rst_n=0 after 2 of 4 load beats → after release, LOAD with load_count=0. Words 0–1 persist until rewritten.
